ysyx_ifu: RTL and testbench

- Instruction fetch unit for the NPC core, directly upstream of the decode/immediate-extension stage.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel with a separate response channel.
- Presents each fetched instruction and its PC to decode through a one-entry valid/ready output buffer.
- Accepts PC redirects from jump/branch resolution and discards wrong-path responses.

---
 rtl/ysyx_ifu.sv | 99 +++++++++
 tb/tb_ysyx_ifu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_ifu.sv
// ysyx_ifu: NPC instruction fetch unit.
// One outstanding imem request; one-entry valid/ready buffer to decode.
module ysyx_ifu #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] tgt;
  logic              cap;

  assign tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_req_addr = pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cap     = 1'b0;
    imem_req_valid = (state == S_REQ) & ~redirect_valid & ~rst;
    inst_valid     = (state == S_HOLD) & ~redirect_valid & ~rst;
    unique case (state)
      S_REQ: begin
        if (redirect_valid)
          pc_n = tgt;
        else if (imem_req_valid & imem_req_ready)
          state_n = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          state_n = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          cap     = 1'b1;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = tgt;
          state_n = S_REQ;
        end else if (inst_valid & inst_ready) begin
          pc_n    = pc + ADDR_W'(4);
          state_n = S_REQ;
        end
      end
      S_DROP: begin
        // wrong-path response still owed; swallow it before refetching
        if (redirect_valid)
          pc_n = tgt;
        if (imem_resp_valid)
          state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      inst     <= '0;
      inst_pc  <= '0;
      misalign <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (cap) begin
        inst    <= imem_resp_data;
        inst_pc <= pc;
      end
      if (redirect_valid & (|redirect_pc[1:0]))
        misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu.sv
// tb_ysyx_ifu: directed scoreboard bench for ysyx_ifu.
// Expected fetch addresses and instructions are queued; a monitor pops them.
module tb_ysyx_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;

  ysyx_ifu #(
    .ADDR_W   (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .misalign        (misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;
  int hs_cnt = 0;
  int fire_cnt = 0;
  int dly = 1;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];
  int          hs_t[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_req(logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_ins(logic [31:0] p);
    exp_pc_q.push_back(p);
    exp_inst_q.push_back(p ^ 32'hFFFF_FFFF);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nsample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hs(int n);
    int k;
    k = 0;
    while (hs_cnt < n && k < 60) begin
      nsample();
      k++;
    end
    chk("wait_handshakes", hs_cnt, n);
  endtask

  task automatic wait_fire(int n);
    int k;
    k = 0;
    while (fire_cnt < n && k < 60) begin
      nsample();
      k++;
    end
    chk("wait_requests", fire_cnt, n);
  endtask

  task automatic wait_iv();
    int k;
    k = 0;
    nsample();
    while (!inst_valid && k < 60) begin
      nsample();
      k++;
    end
    chk("wait_inst_valid", {31'd0, inst_valid}, 32'd1);
  endtask

  // imem model: response dly cycles after acceptance, data = ~addr
  initial begin
    logic        f;
    logic [31:0] a;
    logic [31:0] pa;
    int          cnt;
    f = 1'b0;
    a = '0;
    pa = '0;
    cnt = 0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      f = imem_req_valid && imem_req_ready && !rst;
      a = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (f) begin
          pa  = a;
          cnt = dly;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pa ^ 32'hFFFF_FFFF;
          end
        end
      end
    end
  end

  // monitor: compares every request and every decode handshake
  initial begin
    logic [31:0] e;
    logic [31:0] ei;
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        fire_cnt++;
        if (exp_addr_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL req_unexpected: got addr %h expected none",
                   imem_req_addr);
        end else begin
          e = exp_addr_q.pop_front();
          chk("req_addr", imem_req_addr, e);
        end
      end
      if (!rst && inst_valid && inst_ready) begin
        hs_cnt++;
        hs_t.push_back(cyc);
        if (exp_pc_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL inst_unexpected: got pc %h expected none",
                   inst_pc);
        end else begin
          e  = exp_pc_q.pop_front();
          ei = exp_inst_q.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst", inst, ei);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    nsample();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_addr", imem_req_addr, 32'h8000_0000);

    // zero-wait streaming
    for (int i = 0; i < 5; i++)
      exp_req(32'h8000_0000 + 32'(4 * i));
    for (int i = 0; i < 4; i++)
      exp_ins(32'h8000_0000 + 32'(4 * i));
    step();
    rst = 1'b0;
    inst_ready = 1'b1;
    wait_hs(3);
    chk("rate_0_1", 32'(hs_t[1] - hs_t[0]), 32'd3);
    chk("rate_1_2", 32'(hs_t[2] - hs_t[1]), 32'd3);

    // backpressure on 0x8000_000C
    step();
    inst_ready = 1'b0;
    wait_iv();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nsample();
      chk("bp_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_pc", inst_pc, 32'h8000_000C);
      chk("bp_inst", inst, 32'h7FFF_FFF3);
      chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    step();
    inst_ready = 1'b1;
    dly = 4;

    // redirect while waiting on 0x8000_0010
    wait_fire(5);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    inst_ready = 1'b0;
    exp_req(32'h8000_0100);
    step();
    redirect_valid = 1'b0;
    dly = 1;
    wait_iv();
    chk("drop_pc", inst_pc, 32'h8000_0100);
    chk("drop_inst", inst, 32'h7FFF_FEFF);

    // redirect in hold with inst_ready high
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    inst_ready = 1'b1;
    exp_req(32'h8000_0100);
    exp_ins(32'h8000_0100);
    nsample();
    chk("hold_redir_iv", {31'd0, inst_valid}, 32'd0);
    chk("hold_redir_rv", {31'd0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    wait_hs(5);

    // misaligned redirect
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    exp_req(32'h8000_0100);
    exp_ins(32'h8000_0100);
    nsample();
    chk("mis_req_valid", {31'd0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    nsample();
    chk("misalign_set", {31'd0, misalign}, 32'd1);
    wait_hs(6);
    chk("misalign_sticky", {31'd0, misalign}, 32'd1);

    // reset mid-operation
    step();
    rst = 1'b1;
    step();
    nsample();
    chk("rst2_misalign", {31'd0, misalign}, 32'd0);
    chk("rst2_addr", imem_req_addr, 32'h8000_0000);
    chk("rst2_inst_pc", inst_pc, 32'd0);
    chk("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    exp_req(32'h8000_0000);
    exp_ins(32'h8000_0000);
    step();
    rst = 1'b0;
    wait_hs(7);

    // pc wrap
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_req(32'hFFFF_FFFC);
    exp_ins(32'hFFFF_FFFC);
    exp_req(32'h0000_0000);
    exp_ins(32'h0000_0000);
    step();
    redirect_valid = 1'b0;
    wait_hs(9);
    step();
    imem_req_ready = 1'b0;
    repeat (4) nsample();
    chk("addr_q_left", exp_addr_q.size(), 32'd0);
    chk("inst_q_left", exp_pc_q.size(), 32'd0);
    chk("final_addr", imem_req_addr, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
